// File: rtl/hyperram_pkg.sv
// hyperram_pkg: shared CA field positions, FSM states and register constants for the HyperBus responder
package hyperram_pkg;
    localparam int CA_RD     = 47;
    localparam int CA_REG    = 46;
    localparam int CA_LIN    = 45;
    localparam int CA_ROW_HI = 44;
    localparam int CA_ROW_LO = 16;
    localparam int CA_COL_HI = 2;
    localparam int CA_BYTES  = 6;
    localparam logic [15:0] CR0_DEFAULT  = 16'h8F1F;
    localparam logic [31:0] REG_ID0_ADDR = 32'h0000_0000;
    localparam logic [31:0] REG_CR0_ADDR = 32'h0000_0800;
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CA,
        ST_LAT,
        ST_REGW,
        ST_WDATA,
        ST_RDATA
    } state_t;
endpackage

// File: rtl/hyperram_ck_edge.sv
// hyperram_ck_edge: detects HyperBus CK transitions sampled on clk while chip select is active
module hyperram_ck_edge (
    input  logic clk,
    input  logic rstn,
    input  logic clr,
    input  logic ck,
    input  logic cs_l,
    output logic ck_evt,
    output logic rise
);
    logic ck_q;

    always_ff @(posedge clk or negedge rstn)
        if (!rstn) ck_q <= 1'b0;
        else       ck_q <= clr ? 1'b0 : ck;

    assign ck_evt = ~cs_l & (ck != ck_q);
    assign rise   = ck;
endmodule

// File: rtl/hyperram_responder.sv
// hyperram_responder: HyperBus device model serving a 16-bit word array plus ID0/CR0 registers
module hyperram_responder
    import hyperram_pkg::*;
#(
    parameter int          ADDR_W    = 10,
    parameter int          LAT_EDGES = 12,
    parameter int          FIXED_2X  = 1,
    parameter logic [15:0] ID0_VAL   = 16'h0C81
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        dram_ck,
    input  logic        dram_cs_l,
    input  logic        dram_rst_l,
    input  logic [7:0]  dram_dq_in,
    output logic [7:0]  dram_dq_out,
    output logic        dram_dq_oe_l,
    input  logic        dram_rwds_in,
    output logic        dram_rwds_out,
    output logic        dram_rwds_oe_l,
    output logic        busy,
    output logic        txn_done,
    output logic [47:0] last_ca
);
    localparam logic [7:0] LAT_CNT = 8'(FIXED_2X != 0 ? 2 * LAT_EDGES : LAT_EDGES);
    localparam logic       RWDS_CA = FIXED_2X != 0;

    state_t            state, state_next;
    logic              ck_evt, rise, ca_last;
    logic [39:0]       ca_sr;
    logic [47:0]       ca_full;
    logic [31:0]       ca_wa;
    logic [2:0]        ca_cnt;
    logic [7:0]        cnt;
    logic [ADDR_W-1:0] addr;
    logic              rd_q, reg_q, id_q, k_odd;
    logic [15:0]       cr0, rd_word;
    logic [15:0]       mem [2**ADDR_W];

    hyperram_ck_edge u_ck_edge (
        .clk    (clk),
        .rstn   (rstn),
        .clr    (~dram_rst_l),
        .ck     (dram_ck),
        .cs_l   (dram_cs_l),
        .ck_evt (ck_evt),
        .rise   (rise)
    );

    assign ca_full = {ca_sr, dram_dq_in};
    assign ca_wa   = {ca_full[CA_ROW_HI:CA_ROW_LO], ca_full[CA_COL_HI:0]};
    assign ca_last = state == ST_CA && ca_cnt == 3'(CA_BYTES - 1);
    assign rd_word = reg_q ? (id_q ? ID0_VAL : cr0) : mem[addr];
    assign busy    = state != ST_IDLE;

    always_ff @(posedge clk or negedge rstn)
        if (!rstn) state <= ST_IDLE;
        else       state <= dram_rst_l ? state_next : ST_IDLE;

    always_comb begin
        state_next = state;
        if (dram_cs_l) state_next = ST_IDLE;
        else if (ck_evt)
            case (state)
                ST_IDLE: state_next = ST_CA;
                ST_CA:   if (ca_last) state_next = (!ca_full[CA_RD] && ca_full[CA_REG]) ? ST_REGW : ST_LAT;
                ST_LAT:  if (cnt == 8'd1) state_next = rd_q ? ST_RDATA : ST_WDATA;
                default: state_next = state;
            endcase
    end

    always_ff @(posedge clk or negedge rstn)
        if (!rstn) begin
            ca_sr          <= '0;
            ca_cnt         <= '0;
            cnt            <= '0;
            addr           <= '0;
            {rd_q, reg_q, id_q, k_odd} <= '0;
            cr0            <= CR0_DEFAULT;
            dram_dq_out    <= '0;
            dram_dq_oe_l   <= 1'b1;
            dram_rwds_out  <= 1'b0;
            dram_rwds_oe_l <= 1'b1;
            txn_done       <= 1'b0;
            last_ca        <= '0;
        end else if (!dram_rst_l) begin
            ca_sr          <= '0;
            ca_cnt         <= '0;
            cnt            <= '0;
            addr           <= '0;
            {rd_q, reg_q, id_q, k_odd} <= '0;
            cr0            <= CR0_DEFAULT;
            dram_dq_out    <= '0;
            dram_dq_oe_l   <= 1'b1;
            dram_rwds_out  <= 1'b0;
            dram_rwds_oe_l <= 1'b1;
            txn_done       <= 1'b0;
            last_ca        <= '0;
        end else begin
            txn_done <= 1'b0;
            if (dram_cs_l) begin
                dram_dq_oe_l   <= 1'b1;
                dram_rwds_oe_l <= 1'b1;
                txn_done       <= state != ST_IDLE;
            end else if (ck_evt)
                case (state)
                    ST_IDLE: begin
                        ca_sr          <= ca_full[39:0];
                        ca_cnt         <= 3'd1;
                        dram_rwds_out  <= RWDS_CA;
                        dram_rwds_oe_l <= 1'b0;
                    end
                    ST_CA: begin
                        ca_sr  <= ca_full[39:0];
                        ca_cnt <= ca_cnt + 3'd1;
                        if (ca_last) begin
                            dram_rwds_oe_l <= 1'b1;
                            last_ca        <= ca_full;
                            addr           <= ca_wa[ADDR_W-1:0];
                            rd_q           <= ca_full[CA_RD];
                            reg_q          <= ca_full[CA_REG];
                            id_q           <= ca_wa == REG_ID0_ADDR;
                            k_odd          <= 1'b0;
                            cnt            <= (!ca_full[CA_RD] && ca_full[CA_REG]) ? 8'd0 : LAT_CNT;
                        end
                    end
                    ST_LAT: cnt <= cnt - 8'd1;
                    // register writes take exactly two bytes; anything after is dropped
                    ST_REGW: begin
                        if (cnt == 8'd0) cr0[15:8] <= dram_dq_in;
                        if (cnt == 8'd1) cr0[7:0]  <= dram_dq_in;
                        if (cnt < 8'd2)  cnt       <= cnt + 8'd1;
                    end
                    ST_WDATA: if (!rise) addr <= addr + 1'b1;
                    ST_RDATA: begin
                        dram_dq_out    <= rise ? rd_word[15:8] : rd_word[7:0];
                        dram_rwds_out  <= ~k_odd;
                        k_odd          <= ~k_odd;
                        dram_dq_oe_l   <= 1'b0;
                        dram_rwds_oe_l <= 1'b0;
                        if (!rise && !reg_q) addr <= addr + 1'b1;
                    end
                    default: ;
                endcase
        end

    always_ff @(posedge clk)
        if (dram_rst_l && ck_evt && state == ST_WDATA && !dram_rwds_in) begin
            if (rise) mem[addr][15:8] <= dram_dq_in;
            else      mem[addr][7:0]  <= dram_dq_in;
        end
endmodule

// File: doc/hyperram_responder.md
Name: hyperram_responder

Overview:
Synthesizable HyperBus target (device side) for loopback and simulation against the HyperRAM controller. It runs on the controller clock, detects dram_ck transitions (one per clk cycle), and decodes the 48-bit command-address. It serves memory reads and writes from an internal 16-bit-word array after the configured latency, and serves a small register space (ID0, CR0).

Parameters:
ADDR_W, 10, word-address width; array is 2^ADDR_W x 16 bit.
LAT_EDGES, 12, initial-latency CK edges (1x).
FIXED_2X, 1, 1 = RWDS driven high during CA and latency doubled.
ID0_VAL, 16'h0C81, value returned for register word address 0.

Ports:
clk  in  1  system clock (same as controller hram_clk)
rstn  in  1  async active-low reset
dram_ck  in  1  HyperBus CK from controller; sampled as data
dram_cs_l  in  1  chip select, active low
dram_rst_l  in  1  device reset, active low; synchronous clear of FSM
dram_dq_in  in  8  DQ from controller
dram_dq_out  out  8  DQ driven by responder
dram_dq_oe_l  out  1  DQ output enable, active low
dram_rwds_in  in  1  RWDS from controller (write byte mask, 1 = masked)
dram_rwds_out  out  1  RWDS driven by responder
dram_rwds_oe_l  out  1  RWDS output enable, active low
busy  out  1  high while FSM not IDLE
txn_done  out  1  one-cycle pulse when CS rises after a transaction
last_ca  out  48  CA of most recent transaction

Behaviour:
- Reset (rstn low, async): state IDLE; dq_out=0, rwds_out=0, both oe_l=1, busy=0, txn_done=0, last_ca=0, CR0=16'h8F1F, ck_q=0. Memory array is not reset.
- dram_rst_l low: same clear, synchronous; CR0 reloads default.
- Edge detect: ck_q<=dram_ck every cycle. edge = ~dram_cs_l & (dram_ck != ck_q). Rising when dram_ck=1.
- Byte order: edge 1..6 carry CA[47:40] first. Data bytes: rising edge = word[15:8], falling = word[7:0].
- CA fields: [47] 1=read; [46] 1=register space; [45] 1=linear burst. Word addr = {CA[44:16],CA[2:0]}, truncated to ADDR_W.
- FSM states: IDLE -> CA on first edge -> LAT or REGW after 6th edge -> WDATA or RDATA -> IDLE on CS high.
- IDLE->CA: shift in bytes. rwds_out=FIXED_2X, rwds_oe_l=0 while in CA.
- After 6th edge: release RWDS, latch last_ca. If register write, go to REGW. Otherwise go to LAT with count = FIXED_2X ? 2*LAT_EDGES : LAT_EDGES.
- LAT: decrement on each edge. The edge that makes count 0 is the last latency edge; next state is WDATA or RDATA.
- REGW: zero latency. Edge 7 loads CR0[15:8]; edge 8 loads CR0[7:0]; later edges are ignored.
- WDATA: each edge writes one byte to mem[addr] upper/lower half unless dram_rwds_in=1. addr increments after each falling-edge byte.
- RDATA: on data edge k, register dq_out=byte k, rwds_out=(k even), dq_oe_l=0, rwds_oe_l=0. Outputs are visible one clk after the edge.
- Register read data: addr 0 -> ID0_VAL; otherwise CR0.
- Address wrap: increment modulo 2^ADDR_W. Wrapped bursts (CA[45]=0) are treated as linear.
- CS high in any state: next cycle IDLE, both oe_l=1. Bytes already written persist. Pulse txn_done if state was not IDLE.
- CS high and an edge in the same cycle: the edge is ignored.
- Edges beyond a 2-byte register read repeat the same word.

Decomposition:
- Package hyperram_pkg: CA bit-position constants, FSM state enum, CR0 default, register address constants.
- Sub-module hyperram_ck_edge: ck_q register; outputs edge and rise. Everything else stays in hyperram_responder.

Test Plan:
- Reset: assert rstn low mid-transaction -> dq_oe_l=1, rwds_oe_l=1, busy=0, txn_done=0 immediately.
- Memory write/read: write CA 48'h2000_0002_0000 with 0xDEADBEEF, then read CA 48'hA000_0002_0000 -> bytes DE,AD,BE,EF with rwds_out 1,0,1,0. The first data byte appears after 24 latency edges, and RWDS is high during CA.
- Byte mask: write 0x11223344 to same word with rwds_in=1 on byte 2, then read -> 0x1122BE44.
- Registers: read CA 48'hC000_0000_0000 -> 0x0C81 after latency. Write CA 48'h6000_0100_0000 data 0x8FE6 -> accepted on edges 7-8 with no latency. Read CA 48'hE000_0100_0000 -> 0x8FE6.
- Abort/wrap: raise CS after 2 read bytes -> oe_l=1 next clk, txn_done pulse, back-to-back read correct. Write 2 words at last address 0x3FF -> second word lands at 0x000.
